uart_tx_fifo: RTL

//   Parametrised UART transmitter with an input FIFO, valid/ready host handshake,

---
 rtl/uart_tx_fifo.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: valid/ready push side and a runtime baud divisor.
// Frames go out back-to-back (start, data LSB first, optional parity, 1..2 stop) while words are queued.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q;
  logic                 push, pop, full, have_word;
  logic [DATA_BITS-1:0] head;

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign have_word = (cnt_q != '0);
  assign tx_ready  = !reset && !full;
  assign push      = tx_valid && tx_ready;
  assign head      = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only pointers/count define contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= tx_data;
  end

  // ---------------- Transmit FSM ----------------
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] tmr_q, tmr_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 stp_q, stp_d;
  logic                 tx_q, tx_d;
  logic                 load, tmr_done;

  assign tmr_done = (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      div_q   <= '0;
      shr_q   <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      stp_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      div_q   <= div_d;
      shr_q   <= shr_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      stp_q   <= stp_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    div_d   = div_q;
    shr_d   = shr_q;
    bit_d   = bit_q;
    par_d   = par_q;
    stp_d   = stp_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (have_word) load = 1'b1;
      end
      S_START: begin
        if (tmr_done) begin
          tmr_d   = div_q;
          tx_d    = shr_q[0];
          shr_d   = shr_q >> 1;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          tmr_d = tmr_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (tmr_done) begin
          tmr_d = div_q;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            if (PARITY_MODE != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              stp_d   = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = shr_q[0];
            shr_d = shr_q >> 1;
          end
        end else begin
          tmr_d = tmr_q - DIV_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (tmr_done) begin
          tmr_d   = div_q;
          tx_d    = 1'b1;
          stp_d   = 1'b0;
          state_d = S_STOP;
        end else begin
          tmr_d = tmr_q - DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (tmr_done) begin
          if (stp_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data waits.
            if (have_word) load = 1'b1;
            else           state_d = S_IDLE;
          end else begin
            stp_d = 1'b1;
            tmr_d = div_q;
          end
        end else begin
          tmr_d = tmr_q - DIV_WIDTH'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Frame start: the divisor is captured here and held for the whole frame.
    if (load) begin
      pop     = 1'b1;
      shr_d   = head;
      par_d   = (PARITY_MODE == 2) ? ~^head : ^head;
      div_d   = clk_div;
      tmr_d   = clk_div;
      tx_d    = 1'b0;
      state_d = S_START;
    end
  end

  assign uart_tx    = tx_q;
  assign busy       = (state_q != S_IDLE) || have_word;
  assign fifo_count = cnt_q;

endmodule
